fma_arbiter: RTL and testbench
==============================

FMA_ARBITER -- requirements
Module: fma_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one FMA datapath (2..8).
REQ-002 SHALL have parameter PARM_EXP, default 8, and PARM_MANT, default 23, with operand width W = 1+PARM_EXP+PARM_MANT.
REQ-003 SHALL have parameter PARM_RM, default 3, rounding-mode width.
REQ-004 SHALL have parameter FMA_LAT, default 3, fixed issue-to-result latency of the attached FMA datapath in cycles (>=1).
REQ-005 Ports (name, direction, width, meaning):
 clk_i  in  1  sole clock, rising edge
 rst_n_i  in  1  asynchronous active-low reset
 req_valid_i  in  NUM_REQ  per-requester operation request
 req_ready_o  out  NUM_REQ  per-requester grant; transfer on valid&ready
 req_a_i, req_b_i, req_c_i  in  NUM_REQ*W each  operands; result = A + B*C; slice k belongs to requester k
 req_rm_i  in  NUM_REQ*PARM_RM  per-requester rounding mode
 fma_valid_o  out  1  issue strobe to datapath
 fma_a_o, fma_b_o, fma_c_o  out  W each  issued operands
 fma_rm_o  out  PARM_RM  issued rounding mode
 fma_res_i  in  W  datapath result, valid FMA_LAT cycles after issue
 fma_flags_i  in  4  {invalid, overflow, underflow, inexact} with fma_res_i
 resp_valid_o  out  NUM_REQ  one-hot result strobe to owning requester
 resp_data_o  out  W  result (shared bus)
 resp_flags_o  out  4  flags (shared bus)
 busy_o  out  1  any operation in flight
 flag_clr_i  in  NUM_REQ  clear sticky flags (macro-dependent)
 sticky_flags_o  out  NUM_REQ*4  accumulated flags (macro-dependent)

Function
REQ-006 SHALL grant at most one requester per cycle: req_ready_o is one-hot or zero, combinationally from req_valid_i and the round-robin pointer.
REQ-007 SHALL search round-robin starting at pointer rr_q; grant the first k with req_valid_i[k]; no valid -> req_ready_o = 0.
REQ-008 On a grant to k, rr_q SHALL become (k+1) mod NUM_REQ next cycle; without a grant rr_q SHALL hold.
REQ-009 SHALL register the granted operands/rm and assert fma_valid_o exactly one cycle after the handshake (issue latency 1); fma_valid_o low otherwise, data outputs hold last issued value.
REQ-010 SHALL track ownership in a FMA_LAT-deep shift register of {valid, tag}, tag width clog2(NUM_REQ), entered with fma_valid_o.
REQ-011 SHALL register fma_res_i/fma_flags_i when the tag pipeline tail is valid and assert resp_valid_o[tag] the following cycle; total request-to-response latency = FMA_LAT+2 cycles.
REQ-012 Responses SHALL have no backpressure; requesters must accept resp_valid_o unconditionally.
REQ-013 Results SHALL return in issue order; back-to-back issues sustain one op per cycle with no bubbles.
REQ-014 busy_o SHALL be high whenever issue register, any tag stage, or response register holds a valid entry.
REQ-015 Simultaneous issue and retire SHALL both take effect in the same cycle.

Reset
REQ-016 rst_n_i low SHALL asynchronously clear rr_q to 0, all tag valids, fma_valid_o, resp_valid_o, busy_o, and sticky flags; data registers reset to 0.
REQ-017 In-flight operations at reset SHALL be discarded; no resp_valid_o after reset deasserts for pre-reset issues, even if fma_res_i continues.

Configuration
REQ-018 Macro FMA_ARBITER_STICKY_FLAGS_EN defined: per-requester 4-bit register ORs resp_flags_o into entry tag on each response; flag_clr_i[k] clears entry k; clear and set same cycle -> set wins (new flags retained).
REQ-019 Macro undefined: sticky registers absent, sticky_flags_o tied 0, flag_clr_i ignored.

Verification
REQ-020 All four requesters valid continuously, rr_q=0 -> grants 0,1,2,3,0 on consecutive cycles; responses arrive FMA_LAT+2 cycles after each grant with matching one-hot resp_valid_o.
REQ-021 Only requester 2 valid for 5 cycles -> 5 consecutive grants to 2, rr_q=3 afterward, 5 in-order responses.
REQ-022 Requester 1 issues A=0x3F800000,B=0x40000000,C=0x40400000,RNE with model datapath -> resp_data_o=0x40E00000, flags 0000, on resp_valid_o[1].
REQ-023 Issue 3 ops, assert rst_n_i low for 1 cycle at cycle 2 -> all outputs 0 immediately, no responses for pre-reset ops, busy_o=0.
REQ-024 With macro: requester 0 gets overflow response (flags 0100) then inexact (0001) -> sticky_flags_o[3:0]=0101; flag_clr_i[0] coincident with new invalid response -> 1000.
REQ-025 Idle 10 cycles -> busy_o=0, fma_valid_o=0, rr_q unchanged.

Source files
------------

// File: rtl/fma_arbiter.sv
// Round-robin arbiter that shares one fixed-latency FMA datapath among NUM_REQ requesters.
// Optional per-requester sticky exception flags are enabled by defining FMA_ARBITER_STICKY_FLAGS_EN.
module fma_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23,
    parameter int PARM_RM   = 3,
    parameter int FMA_LAT   = 3,
    localparam int W        = 1 + PARM_EXP + PARM_MANT
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*W-1:0]       req_a_i,
    input  logic [NUM_REQ*W-1:0]       req_b_i,
    input  logic [NUM_REQ*W-1:0]       req_c_i,
    input  logic [NUM_REQ*PARM_RM-1:0] req_rm_i,
    output logic                       fma_valid_o,
    output logic [W-1:0]               fma_a_o,
    output logic [W-1:0]               fma_b_o,
    output logic [W-1:0]               fma_c_o,
    output logic [PARM_RM-1:0]         fma_rm_o,
    input  logic [W-1:0]               fma_res_i,
    input  logic [3:0]                 fma_flags_i,
    output logic [NUM_REQ-1:0]         resp_valid_o,
    output logic [W-1:0]               resp_data_o,
    output logic [3:0]                 resp_flags_o,
    output logic                       busy_o,
    input  logic [NUM_REQ-1:0]         flag_clr_i,
    output logic [NUM_REQ*4-1:0]       sticky_flags_o
);

    localparam int TAG_W = $clog2(NUM_REQ);

    logic [TAG_W-1:0]               rr_q, rr_d;
    logic                           gnt_vld;
    logic [TAG_W-1:0]               gnt_idx;
    logic [TAG_W-1:0]               cand;

    logic                           fma_valid_q, fma_valid_d;
    logic [TAG_W-1:0]               fma_tag_q, fma_tag_d;
    logic [W-1:0]                   fma_a_q, fma_a_d;
    logic [W-1:0]                   fma_b_q, fma_b_d;
    logic [W-1:0]                   fma_c_q, fma_c_d;
    logic [PARM_RM-1:0]             fma_rm_q, fma_rm_d;

    logic [FMA_LAT-1:0]             tag_vld_q, tag_vld_d;
    logic [FMA_LAT-1:0][TAG_W-1:0]  tag_q, tag_d;

    logic [NUM_REQ-1:0]             resp_valid_q, resp_valid_d;
    logic [W-1:0]                   resp_data_q, resp_data_d;
    logic [3:0]                     resp_flags_q, resp_flags_d;

    logic [W-1:0]                   a_arr  [NUM_REQ];
    logic [W-1:0]                   b_arr  [NUM_REQ];
    logic [W-1:0]                   c_arr  [NUM_REQ];
    logic [PARM_RM-1:0]             rm_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
        assign a_arr[k]  = req_a_i[k*W +: W];
        assign b_arr[k]  = req_b_i[k*W +: W];
        assign c_arr[k]  = req_c_i[k*W +: W];
        assign rm_arr[k] = req_rm_i[k*PARM_RM +: PARM_RM];
    end

    // Rotating search: the first valid requester at or after rr_q wins.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        gnt_vld     = 1'b0;
        gnt_idx     = '0;
        cand        = '0;
        req_ready_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = TAG_W'((int'(rr_q) + i) % NUM_REQ);
            if (!gnt_vld && req_valid_i[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_vld) req_ready_o[gnt_idx] = 1'b1;
        rr_d = rr_q;
        if (gnt_vld) rr_d = (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_comb begin
        fma_valid_d = gnt_vld;
        fma_tag_d   = fma_tag_q;
        fma_a_d     = fma_a_q;
        fma_b_d     = fma_b_q;
        fma_c_d     = fma_c_q;
        fma_rm_d    = fma_rm_q;
        if (gnt_vld) begin
            fma_tag_d = gnt_idx;
            fma_a_d   = a_arr[gnt_idx];
            fma_b_d   = b_arr[gnt_idx];
            fma_c_d   = c_arr[gnt_idx];
            fma_rm_d  = rm_arr[gnt_idx];
        end

        // Ownership tags travel alongside the datapath so the tail lines up with fma_res_i.
        tag_vld_d    = '0;
        tag_d        = '0;
        tag_vld_d[0] = fma_valid_q;
        tag_d[0]     = fma_tag_q;
        for (int i = 1; i < FMA_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_d[i]     = tag_q[i-1];
        end

        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        resp_flags_d = resp_flags_q;
        if (tag_vld_q[FMA_LAT-1]) begin
            resp_valid_d[tag_q[FMA_LAT-1]] = 1'b1;
            resp_data_d  = fma_res_i;
            resp_flags_d = fma_flags_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: datapath registers are reset too, so outputs read as zero straight out of reset.
        if (!rst_n_i) begin
            rr_q         <= '0;
            fma_valid_q  <= 1'b0;
            fma_tag_q    <= '0;
            fma_a_q      <= '0;
            fma_b_q      <= '0;
            fma_c_q      <= '0;
            fma_rm_q     <= '0;
            tag_vld_q    <= '0;
            tag_q        <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_flags_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            rr_q         <= rr_d;
            fma_valid_q  <= fma_valid_d;
            fma_tag_q    <= fma_tag_d;
            fma_a_q      <= fma_a_d;
            fma_b_q      <= fma_b_d;
            fma_c_q      <= fma_c_d;
            fma_rm_q     <= fma_rm_d;
            tag_vld_q    <= tag_vld_d;
            tag_q        <= tag_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_flags_q <= resp_flags_d;
        end
    end

    assign fma_valid_o  = fma_valid_q;
    assign fma_a_o      = fma_a_q;
    assign fma_b_o      = fma_b_q;
    assign fma_c_o      = fma_c_q;
    assign fma_rm_o     = fma_rm_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign resp_flags_o = resp_flags_q;
    assign busy_o       = fma_valid_q | (|tag_vld_q) | (|resp_valid_q);

`ifdef FMA_ARBITER_STICKY_FLAGS_EN
    logic [NUM_REQ-1:0][3:0] sticky_q, sticky_d;

    // A response arriving in the same cycle as a clear survives the clear.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            sticky_d[k] = flag_clr_i[k] ? 4'b0000 : sticky_q[k];
            if (resp_valid_q[k]) sticky_d[k] = sticky_d[k] | resp_flags_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) sticky_q <= '0;
        else          sticky_q <= sticky_d;
    end

    assign sticky_flags_o = sticky_q;
`else
    logic unused_flag_clr;
    assign unused_flag_clr = ^flag_clr_i;
    assign sticky_flags_o  = '0;
`endif

endmodule

// File: tb/tb_fma_arbiter.sv
// Self-checking bench for fma_arbiter: vector table, directed corner sequences and random traffic
// scored against a transaction-level model (grant order, response queue, per-requester flag sets).
module tb_fma_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int RM = 3;
    localparam int L  = 3;
`ifdef FMA_ARBITER_STICKY_FLAGS_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n_i;
    logic [N-1:0]      req_valid_i;
    logic [N-1:0]      req_ready_o;
    logic [N*W-1:0]    req_a_i, req_b_i, req_c_i;
    logic [N*RM-1:0]   req_rm_i;
    logic              fma_valid_o;
    logic [W-1:0]      fma_a_o, fma_b_o, fma_c_o;
    logic [RM-1:0]     fma_rm_o;
    logic [W-1:0]      fma_res_i;
    logic [3:0]        fma_flags_i;
    logic [N-1:0]      resp_valid_o;
    logic [W-1:0]      resp_data_o;
    logic [3:0]        resp_flags_o;
    logic              busy_o;
    logic [N-1:0]      flag_clr_i;
    logic [N*4-1:0]    sticky_flags_o;

    fma_arbiter #(.NUM_REQ(N), .PARM_EXP(8), .PARM_MANT(23), .PARM_RM(RM), .FMA_LAT(L)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_c_i(req_c_i), .req_rm_i(req_rm_i),
        .fma_valid_o(fma_valid_o), .fma_a_o(fma_a_o), .fma_b_o(fma_b_o), .fma_c_o(fma_c_o),
        .fma_rm_o(fma_rm_o), .fma_res_i(fma_res_i), .fma_flags_i(fma_flags_i),
        .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_flags_o(resp_flags_o),
        .busy_o(busy_o), .flag_clr_i(flag_clr_i), .sticky_flags_o(sticky_flags_o)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] data; logic [3:0] flags; } dp_t;
    typedef struct { int tag; int due; logic [31:0] data; logic [3:0] flags; } exp_t;
    typedef struct { logic [N-1:0] vld; logic [N-1:0] rdy; } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural single-precision FMA via double arithmetic (truncating; rm only routed).
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic dp_t dp_fn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        dp_t r;
        real x;
        logic [63:0] d;
        int e;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF || c[30:23] == 8'hFF) return '{32'h7FC00000, 4'b1000};
        x = f2r(a) + f2r(b) * f2r(c);
        if (x == 0.0) return '{32'h0, 4'b0000};
        d = $realtobits(x);
        e = int'(d[62:52]) - 896;
        if (e >= 255)     r = '{{d[63], 8'hFF, 23'h0}, 4'b0100};
        else if (e <= 0)  r = '{{d[63], 31'h0}, 4'b0011};
        else              r = '{{d[63], e[7:0], d[51:29]}, {3'b000, |d[28:0]}};
        return r;
    endfunction

    // Datapath model: result appears FMA_LAT cycles after issue; keeps running through reset.
    logic [31:0] pipe_d [L];
    logic [3:0]  pipe_f [L];
    always @(posedge clk) begin
        dp_t r;
        r = dp_fn(fma_a_o, fma_b_o, fma_c_o);
        pipe_d[0] <= r.data;
        pipe_f[0] <= r.flags;
        for (int i = 1; i < L; i++) begin
            pipe_d[i] <= pipe_d[i-1];
            pipe_f[i] <= pipe_f[i-1];
        end
    end
    assign fma_res_i   = pipe_d[L-1];
    assign fma_flags_i = pipe_f[L-1];

    // Transaction-level reference state.
    exp_t              sb [$];
    int                rr_m = 0;
    logic              iss_vld = 1'b0;
    logic [31:0]       iss_a, iss_b, iss_c;
    logic [RM-1:0]     iss_rm;
    logic [N-1:0][3:0] st_m = '0;
    logic [31:0]       op_a [N];
    logic [31:0]       op_b [N];
    logic [31:0]       op_c [N];
    logic [RM-1:0]     op_rm [N];
    logic [N-1:0]      clr_drv = '0;
    logic [N-1:0]      rdy_seen;
    logic [N-1:0]      resp_seen_vld;
    logic [31:0]       resp_seen_data;
    logic [3:0]        resp_seen_flags;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rand_op();
        return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
    endfunction

    task automatic rand_ops();
        for (int k = 0; k < N; k++) begin
            op_a[k]  = rand_op();
            op_b[k]  = rand_op();
            op_c[k]  = rand_op();
            op_rm[k] = RM'($urandom);
        end
    endtask

    // One clock cycle: drive after the rising edge, score on the falling edge.
    task automatic do_cycle(input logic [N-1:0] vld);
        int g;
        logic exp_busy;
        dp_t r;
        @(posedge clk);
        #1;
        req_valid_i = vld;
        flag_clr_i  = clr_drv;
        for (int k = 0; k < N; k++) begin
            req_a_i[k*W +: W]    = op_a[k];
            req_b_i[k*W +: W]    = op_b[k];
            req_c_i[k*W +: W]    = op_c[k];
            req_rm_i[k*RM +: RM] = op_rm[k];
        end
        @(negedge clk);
        cyc++;
        g = -1;
        for (int i = 0; i < N; i++) begin
            if (g < 0 && vld[(rr_m + i) % N]) g = (rr_m + i) % N;
        end
        rdy_seen = req_ready_o;
        check("req_ready", 64'(req_ready_o), (g >= 0) ? 64'(1) << g : 64'(0));

        check("fma_valid", 64'(fma_valid_o), 64'(iss_vld));
        if (iss_vld) begin
            check("fma_a", 64'(fma_a_o), 64'(iss_a));
            check("fma_b", 64'(fma_b_o), 64'(iss_b));
            check("fma_c", 64'(fma_c_o), 64'(iss_c));
            check("fma_rm", 64'(fma_rm_o), 64'(iss_rm));
        end

        exp_busy = 1'b0;
        foreach (sb[i]) if (cyc >= sb[i].due - L - 1 && cyc <= sb[i].due) exp_busy = 1'b1;
        check("busy", 64'(busy_o), 64'(exp_busy));
        check("sticky", 64'(sticky_flags_o), 64'(st_m));

        if (STICKY) for (int k = 0; k < N; k++) if (clr_drv[k]) st_m[k] = 4'b0000;
        if (resp_valid_o != '0) begin
            resp_seen_vld   = resp_valid_o;
            resp_seen_data  = resp_data_o;
            resp_seen_flags = resp_flags_o;
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            check("resp_valid", 64'(resp_valid_o), 64'(1) << sb[0].tag);
            check("resp_data", 64'(resp_data_o), 64'(sb[0].data));
            check("resp_flags", 64'(resp_flags_o), 64'(sb[0].flags));
            if (STICKY) st_m[sb[0].tag] = st_m[sb[0].tag] | sb[0].flags;
            void'(sb.pop_front());
        end else begin
            check("resp_idle", 64'(resp_valid_o), 64'(0));
        end

        if (g >= 0) begin
            r = dp_fn(op_a[g], op_b[g], op_c[g]);
            sb.push_back('{g, cyc + L + 2, r.data, r.flags});
            rr_m    = (g + 1) % N;
            iss_vld = 1'b1;
            iss_a   = op_a[g];
            iss_b   = op_b[g];
            iss_c   = op_c[g];
            iss_rm  = op_rm[g];
        end else begin
            iss_vld = 1'b0;
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) do_cycle('0);
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        req_valid_i = '0;
        flag_clr_i  = '0;
        rst_n_i     = 1'b0;
        #1;
        check("rst fma_valid", 64'(fma_valid_o), 64'(0));
        check("rst resp_valid", 64'(resp_valid_o), 64'(0));
        check("rst busy", 64'(busy_o), 64'(0));
        check("rst fma_a", 64'(fma_a_o), 64'(0));
        check("rst resp_data", 64'(resp_data_o), 64'(0));
        check("rst sticky", 64'(sticky_flags_o), 64'(0));
        check("rst ready", 64'(req_ready_o), 64'(0));
        sb.delete();
        rr_m    = 0;
        iss_vld = 1'b0;
        st_m    = '0;
        clr_drv = '0;
        @(posedge clk);
        #2;
        rst_n_i = 1'b1;
    endtask

    initial begin
        vec_t tbl [14];
        tbl[0]  = '{4'b1111, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b0010};
        tbl[2]  = '{4'b1111, 4'b0100};
        tbl[3]  = '{4'b1111, 4'b1000};
        tbl[4]  = '{4'b1111, 4'b0001};
        tbl[5]  = '{4'b0000, 4'b0000};
        tbl[6]  = '{4'b0001, 4'b0001};
        tbl[7]  = '{4'b1000, 4'b1000};
        tbl[8]  = '{4'b0110, 4'b0010};
        tbl[9]  = '{4'b0101, 4'b0100};
        tbl[10] = '{4'b0011, 4'b0001};
        tbl[11] = '{4'b1010, 4'b0010};
        tbl[12] = '{4'b1011, 4'b1000};
        tbl[13] = '{4'b0100, 4'b0100};

        rst_n_i     = 1'b0;
        req_valid_i = '0;
        flag_clr_i  = '0;
        req_a_i     = '0;
        req_b_i     = '0;
        req_c_i     = '0;
        req_rm_i    = '0;
        rand_ops();
        do_reset();

        // Grant-order table, starting from rr = 0 (first five rows: all requesters valid).
        for (int i = 0; i < 14; i++) begin
            do_cycle(tbl[i].vld);
            check($sformatf("table row %0d", i), 64'(rdy_seen), 64'(tbl[i].rdy));
        end
        drain(L + 4);

        // Single requester holds the bus for 5 cycles, pointer ends at 3.
        do_reset();
        for (int i = 0; i < 5; i++) do_cycle(4'b0100);
        do_cycle(4'b1111);
        check("rr after solo", 64'(rdy_seen), 64'(4'b1000));
        drain(L + 4);

        // Known arithmetic result: 1.0 + 2.0*3.0 = 7.0 on requester 1.
        do_reset();
        op_a[1] = 32'h3F800000;
        op_b[1] = 32'h40000000;
        op_c[1] = 32'h40400000;
        op_rm[1] = 3'd0;
        resp_seen_vld = '0;
        do_cycle(4'b0010);
        drain(L + 3);
        check("fma7 owner", 64'(resp_seen_vld), 64'(4'b0010));
        check("fma7 data", 64'(resp_seen_data), 64'(32'h40E00000));
        check("fma7 flags", 64'(resp_seen_flags), 64'(4'b0000));

        // Reset with operations in flight: nothing may come back afterwards.
        do_reset();
        for (int i = 0; i < 3; i++) do_cycle(4'b1111);
        do_reset();
        resp_seen_vld = '0;
        drain(L + 6);
        check("no stale resp", 64'(resp_seen_vld), 64'(0));

        // Idle period leaves pointer where the last grant put it.
        do_reset();
        do_cycle(4'b0010);
        drain(10);
        check("idle busy", 64'(busy_o), 64'(0));
        check("idle fma_valid", 64'(fma_valid_o), 64'(0));
        do_cycle(4'b1111);
        check("rr after idle", 64'(rdy_seen), 64'(4'b0100));
        drain(L + 4);

        // Sticky flags: overflow then inexact, then clear coincident with an invalid response.
        do_reset();
        op_a[0] = 32'h00000000; op_b[0] = 32'h7F000000; op_c[0] = 32'h7F000000;
        do_cycle(4'b0001);
        op_a[0] = 32'h3F800000; op_b[0] = 32'h3F800000; op_c[0] = 32'h30800000;
        do_cycle(4'b0001);
        drain(L + 4);
`ifdef FMA_ARBITER_STICKY_FLAGS_EN
        check("sticky ovf+inx", 64'(sticky_flags_o[3:0]), 64'(4'b0101));
`else
        check("sticky absent", 64'(sticky_flags_o), 64'(0));
`endif
        op_a[0] = 32'h7FC00000;
        do_cycle(4'b0001);
        drain(L + 1);
        clr_drv = 4'b0001;
        do_cycle('0);
        clr_drv = '0;
        do_cycle('0);
`ifdef FMA_ARBITER_STICKY_FLAGS_EN
        check("sticky clr vs set", 64'(sticky_flags_o[3:0]), 64'(4'b1000));
`else
        check("sticky absent", 64'(sticky_flags_o), 64'(0));
`endif

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rand_ops();
            clr_drv = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            do_cycle(N'($urandom));
        end
        clr_drv = '0;
        drain(L + 4);
        check("final busy", 64'(busy_o), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
